junction_route_scheduler: RTL and testbench

- Sequences the drive block's junction handling from a pre-programmed route table.
- Sits between the drive controller and the tone-direction input; replaces or augments live tone decoding.
- When the drive controller asserts enableToneDetection at a junction, waits a settle window, then presents the next stored direction code on toneDir until the controller accepts it.
- Advances through the route and reports progress and completion.

---
 rtl/junction_route_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_junction_route_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/junction_route_scheduler.sv
// ----------------------------------------------------------------------------
// junction_route_scheduler
//
// Purpose:
//   Plays back a pre-programmed route table to the drive controller.
//   Each time the controller raises enableToneDetection at a junction, the
//   scheduler waits for the enable to stay high for a settle window. It then
//   presents the next stored direction code on toneDir. The code is held
//   until the controller drops enable, and then the route advances.
//
// Direction codes:
//   HOLD=0, FORWARD=1, LEFT=2, RIGHT=3, REVERSE=4, STOP=5 (6 and 7 are illegal).
//
// Optional build macro:
//   ROUTE_LOOP_EN - after the last (non-STOP) entry, the route wraps to
//                   entry 0 instead of finishing. Only a STOP entry or an
//                   abort ends the route.
//
// Ports:
//   clk                 system clock
//   rst                 synchronous, active-low reset
//   cfgWe               route table write strobe (IDLE/DONE only)
//   cfgAddr             table write address
//   cfgData             direction code to store (illegal codes stored as STOP)
//   cfgLenWe            route length write strobe (IDLE/DONE only)
//   cfgLen              route length, clamped to DEPTH
//   start               one-cycle pulse: begin route at entry 0
//   abort               one-cycle pulse: return to IDLE
//   enableToneDetection junction awaiting decision (from drive controller)
//   toneDir             direction code to the drive controller
//   routeIndex          index of the next entry to issue
//   busy                high in WAIT_JCT/SETTLE/ISSUE
//   routeDone           high in DONE
//   cfgErr              one-cycle pulse on a config write rejected while busy
// ----------------------------------------------------------------------------
module junction_route_scheduler #(
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 1_000_000,
  localparam int IW           = $clog2(DEPTH),
  localparam int LW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfgWe,
  input  logic [IW-1:0] cfgAddr,
  input  logic [2:0]    cfgData,
  input  logic          cfgLenWe,
  input  logic [LW-1:0] cfgLen,
  input  logic          start,
  input  logic          abort,
  input  logic          enableToneDetection,
  output logic [2:0]    toneDir,
  output logic [IW-1:0] routeIndex,
  output logic          busy,
  output logic          routeDone,
  output logic          cfgErr
);

  localparam logic [2:0] DIR_HOLD    = 3'd0;
  localparam logic [2:0] DIR_FORWARD = 3'd1;
  localparam logic [2:0] DIR_STOP    = 3'd5;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_JCT,
    SETTLE,
    ISSUE,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    route_table [DEPTH];
  logic [LW-1:0] route_len;
  logic [CW-1:0] settle_cnt;
  logic [2:0]    tone_dir_q;
  logic [IW-1:0] route_index_q;
  logic          cfg_err_q;

  logic          cfg_open;
  logic [2:0]    cur_entry;
  logic          is_last;
  logic [2:0]    store_data;
  logic [LW-1:0] store_len;

  assign cfg_open   = (state == IDLE) || (state == DONE);
  assign cur_entry  = route_table[route_index_q];
  // The last entry is reached when index+1 equals the stored length.
  assign is_last    = ((LW'(route_index_q) + LW'(1)) == route_len);
  assign store_data = (cfgData > DIR_STOP) ? DIR_STOP : cfgData;
  assign store_len  = (cfgLen > LW'(DEPTH)) ? LW'(DEPTH) : cfgLen;

  assign toneDir    = tone_dir_q;
  assign routeIndex = route_index_q;
  assign busy       = (state == WAIT_JCT) || (state == SETTLE) || (state == ISSUE);
  assign routeDone  = (state == DONE);
  assign cfgErr     = cfg_err_q;

  // Route table and length: writable only while the route is not running.
  // A write attempt while busy is dropped and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        route_table[i] <= DIR_STOP;
      end
      route_len <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (cfgWe || cfgLenWe) && !cfg_open;
      if (cfgWe && cfg_open) begin
        route_table[cfgAddr] <= store_data;
      end
      if (cfgLenWe && cfg_open) begin
        route_len <= store_len;
      end
    end
  end

  // Junction sequencing FSM. abort takes precedence over everything else,
  // including a start pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      tone_dir_q    <= DIR_HOLD;
      route_index_q <= '0;
      settle_cnt    <= '0;
    end else if (abort) begin
      state         <= IDLE;
      tone_dir_q    <= DIR_HOLD;
      route_index_q <= '0;
      settle_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          tone_dir_q <= DIR_HOLD;
          if (start) begin
            route_index_q <= '0;
            state         <= (route_len != '0) ? WAIT_JCT : DONE;
          end
        end
        WAIT_JCT: begin
          tone_dir_q <= DIR_HOLD;
          if (enableToneDetection) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Dropping enable before the window expires is treated as a glitch.
          if (!enableToneDetection) begin
            settle_cnt <= '0;
            state      <= WAIT_JCT;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ISSUE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        ISSUE: begin
          if (enableToneDetection) begin
            // A stored HOLD would stall the vehicle, so it is issued as FORWARD.
            tone_dir_q <= (cur_entry == DIR_HOLD) ? DIR_FORWARD : cur_entry;
          end else begin
            tone_dir_q <= DIR_HOLD;
            if (cur_entry == DIR_STOP) begin
              state <= DONE;
            end else if (is_last) begin
`ifdef ROUTE_LOOP_EN
              route_index_q <= '0;
              state         <= WAIT_JCT;
`else
              state         <= DONE;
`endif
            end else begin
              route_index_q <= route_index_q + IW'(1);
              state         <= WAIT_JCT;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tone_dir_q <= DIR_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_junction_route_scheduler.sv
// ----------------------------------------------------------------------------
// tb_junction_route_scheduler
//
// Directed bench for junction_route_scheduler with SETTLE_CYCLES=4, so a
// direction code is first valid 6 cycles after enable rises. Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_junction_route_scheduler;

  logic       clk;
  logic       rst;
  logic       cfgWe;
  logic [2:0] cfgAddr;
  logic [2:0] cfgData;
  logic       cfgLenWe;
  logic [3:0] cfgLen;
  logic       start;
  logic       abort;
  logic       enableToneDetection;
  logic [2:0] toneDir;
  logic [2:0] routeIndex;
  logic       busy;
  logic       routeDone;
  logic       cfgErr;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  junction_route_scheduler #(
    .DEPTH         (8),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfgWe               (cfgWe),
    .cfgAddr             (cfgAddr),
    .cfgData             (cfgData),
    .cfgLenWe            (cfgLenWe),
    .cfgLen              (cfgLen),
    .start               (start),
    .abort               (abort),
    .enableToneDetection (enableToneDetection),
    .toneDir             (toneDir),
    .routeIndex          (routeIndex),
    .busy                (busy),
    .routeDone           (routeDone),
    .cfgErr              (cfgErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic writeEntry(input logic [2:0] addr, input logic [2:0] data);
    cfgWe   = 1'b1;
    cfgAddr = addr;
    cfgData = data;
    tick();
    cfgWe   = 1'b0;
  endtask

  task automatic writeLen(input logic [3:0] len);
    cfgLenWe = 1'b1;
    cfgLen   = len;
    tick();
    cfgLenWe = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // One junction: enable held for highCycles edges, then dropped.
  task automatic applyStimulus(input string tag, input logic [2:0] code,
                               input int highCycles);
    enableToneDetection = 1'b1;
    repeat (5) tick();
    checkOutput({tag, "_early"}, toneDir, 0);
    tick();
    checkOutput({tag, "_valid"}, toneDir, code);
    repeat (highCycles - 6) tick();
    checkOutput({tag, "_held"}, toneDir, code);
    enableToneDetection = 1'b0;
    tick();
    checkOutput({tag, "_release"}, toneDir, 0);
  endtask

  initial begin
    rst = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgData = '0;
    cfgLenWe = 1'b0; cfgLen = '0; start = 1'b1; abort = 1'b0;
    enableToneDetection = 1'b0;

    // Reset held with start asserted.
    tick(); tick();
    checkOutput("rst_toneDir", toneDir, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", routeDone, 0);
    checkOutput("rst_index", routeIndex, 0);
    rst = 1'b1; start = 1'b0;
    tick();
    checkOutput("rst_start_ignored", busy, 0);

    // Full route LEFT, RIGHT, FORWARD; last write shares a cycle with length.
    writeEntry(3'd0, 3'd2);
    writeEntry(3'd1, 3'd3);
    cfgLenWe = 1'b1; cfgLen = 4'd3;
    writeEntry(3'd2, 3'd1);
    cfgLenWe = 1'b0;
    pulseStart();
    checkOutput("route_busy", busy, 1);
    checkOutput("route_index0", routeIndex, 0);
    applyStimulus("j0", 3'd2, 20);
    checkOutput("route_index1", routeIndex, 1);
    applyStimulus("j1", 3'd3, 20);
    checkOutput("route_index2", routeIndex, 2);
    applyStimulus("j2", 3'd1, 20);
    checkOutput("route_done", routeDone, 1);
    checkOutput("route_done_busy", busy, 0);
    checkOutput("route_done_index", routeIndex, 2);

    // Glitch rejection, then a real junction.
    pulseStart();
    enableToneDetection = 1'b1;
    tick(); tick();
    enableToneDetection = 1'b0;
    tick();
    checkOutput("glitch_tone", toneDir, 0);
    checkOutput("glitch_index", routeIndex, 0);
    repeat (6) tick();
    checkOutput("glitch_tone_late", toneDir, 0);
    checkOutput("glitch_busy", busy, 1);
    applyStimulus("gj0", 3'd2, 10);
    checkOutput("glitch_index_adv", routeIndex, 1);

    // Config write while busy is rejected.
    writeEntry(3'd0, 3'd4);
    checkOutput("busy_cfgErr", cfgErr, 1);
    tick();
    checkOutput("busy_cfgErr_clear", cfgErr, 0);

    // abort beats start.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", routeDone, 0);
    checkOutput("abort_index", routeIndex, 0);
    tick();
    checkOutput("abort_start_ignored", busy, 0);

    // Entry 0 still LEFT after the rejected write.
    pulseStart();
    applyStimulus("unchanged", 3'd2, 10);
    pulseAbort();

    // Illegal code stored as STOP ends the route early.
    writeEntry(3'd0, 3'd1);
    writeEntry(3'd1, 3'd7);
    writeEntry(3'd2, 3'd3);
    writeLen(4'd3);
    pulseStart();
    applyStimulus("stop_j0", 3'd1, 10);
    applyStimulus("stop_j1", 3'd5, 10);
    checkOutput("stop_done", routeDone, 1);
    checkOutput("stop_index", routeIndex, 1);

    // Stored HOLD is issued as FORWARD; length 1 route.
    writeEntry(3'd0, 3'd0);
    writeLen(4'd1);
    pulseStart();
    applyStimulus("hold_fwd", 3'd1, 10);
`ifdef ROUTE_LOOP_EN
    checkOutput("hold_loop_busy", busy, 1);
    checkOutput("hold_loop_done", routeDone, 0);
`else
    checkOutput("hold_done", routeDone, 1);
`endif
    checkOutput("hold_index", routeIndex, 0);
    pulseAbort();

    // Zero length goes straight to DONE.
    writeLen(4'd0);
    pulseStart();
    checkOutput("len0_done", routeDone, 1);
    checkOutput("len0_busy", busy, 0);

    // Two-entry route: finishes, or wraps when looping is built in.
    writeEntry(3'd0, 3'd2);
    writeEntry(3'd1, 3'd3);
    writeLen(4'd2);
    pulseStart();
    applyStimulus("loop_a", 3'd2, 10);
    applyStimulus("loop_b", 3'd3, 10);
`ifdef ROUTE_LOOP_EN
    checkOutput("loop_wrap_index", routeIndex, 0);
    checkOutput("loop_wrap_done", routeDone, 0);
    applyStimulus("loop_c", 3'd2, 10);
    applyStimulus("loop_d", 3'd3, 10);
    checkOutput("loop_end_done", routeDone, 0);
    checkOutput("loop_end_busy", busy, 1);
    pulseAbort();
`else
    checkOutput("last_done", routeDone, 1);
    checkOutput("last_index", routeIndex, 1);
    checkOutput("last_busy", busy, 0);
`endif

    // Reset mid-route discards progress and table contents.
    pulseStart();
    enableToneDetection = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; enableToneDetection = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_index", routeIndex, 0);
    checkOutput("midrst_tone", toneDir, 0);
    writeLen(4'd1);
    pulseStart();
    applyStimulus("midrst_stop", 3'd5, 10);
    checkOutput("midrst_done", routeDone, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
